ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Takes the same two 32-bit operands the ALU receives and owns the architectural HI/LO registers.
- Hi/Lo outputs feed the EX result mux for MFHI/MFLO.
- Busy is the stall request to the hazard unit while an operation is in flight.

---
 rtl/ex_muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a single sign-fixup cycle.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int ITERS = WIDTH;
  localparam int CNT_W = $clog2(ITERS);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   wh_q, wh_d, wl_q, wl_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               na_q, na_d, nb_q, nb_d, div_q, div_d, dz_q, dz_d;
  logic               done_q, done_d;

  logic               sgn;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic neg,
                                                       input logic [2*WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wh_d    = wh_q;
    wl_d    = wl_q;
    b_d     = b_q;
    na_d    = na_q;
    nb_d    = nb_q;
    div_d   = div_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    sgn     = (Op == OP_MULT) || (Op == OP_DIV);
    sum     = {1'b0, wh_q} + (wl_q[0] ? {1'b0, b_q} : '0);
    shifted = {wh_q, wl_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    prod    = cond_neg_wide(na_q ^ nb_q, {wh_q, wl_q});
    quo     = dz_q ? '1 : cond_neg(na_q ^ nb_q, wl_q);

    unique case (state_q)
      IDLE: begin
        // Flush squashes any request in the same cycle, including MTHI/MTLO
        if (Start && !Flush) begin
          unique case (Op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              na_d    = sgn & In1[WIDTH-1];
              nb_d    = sgn & In2[WIDTH-1];
              div_d   = Op[1];
              dz_d    = (In2 == '0);
              b_d     = cond_neg(sgn & In2[WIDTH-1], In2);
              wl_d    = cond_neg(sgn & In1[WIDTH-1], In1);
              wh_d    = '0;
              cnt_d   = '0;
              state_d = CALC;
            end
            OP_MTHI: hi_d = In1;
            OP_MTLO: lo_d = In1;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          if (div_q) begin
            // Restoring step: keep the shifted partial remainder when the subtract borrows
            wh_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            wl_d = {wl_q[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            wh_d = sum[WIDTH:1];
            wl_d = {sum[0], wl_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!Flush) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = cond_neg(na_q, wh_q);
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      b_q     <= '0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      b_q     <= b_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: arithmetic results, latency, flush and reset.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd6;
  logic [31:0] In1 = '0;
  logic [31:0] In2 = '0;
  logic        Flush = 1'b0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .In1(In1), .In2(In2),
    .Flush(Flush), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  // Presents one request for a single edge; returns at the negedge after it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; Op = op; In1 = a; In2 = b;
    @(negedge clk);
    Start = 1'b0; Op = 3'd6;
  endtask

  // Counts Busy cycles (bounded), then captures Done/Hi/Lo on the first idle cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic d1, output logic d2,
                        output logic [31:0] h, output logic [31:0] l);
    issue(op, a, b);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    d1 = Done; h = Hi; l = Lo;
    @(negedge clk);
    d2 = Done;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", Done); end
    n_cmp++; if (Hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", Hi); end
    n_cmp++; if (Lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", Lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mult;
    int n; logic d1, d2; logic [31:0] h, l;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, n, d1, d2, h, l);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL mult_latency: got %0d want 33", n); end
    n_cmp++; if (d1 !== 1'b1) begin n_err++; $display("FAIL mult_done: got %b want 1", d1); end
    n_cmp++; if (d2 !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse: got %b want 0", d2); end
    n_cmp++; if (h !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", h); end
    n_cmp++; if (l !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mult_lo: got %h want fffffff1", l); end
  endtask

  task automatic test_multu;
    int n; logic d1, d2; logic [31:0] h, l;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, d1, d2, h, l);
    n_cmp++; if (h !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", h); end
    n_cmp++; if (l !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", l); end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    n_cmp++; if (Done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", Done); end
    n_cmp++; if (Hi !== 32'h0) begin n_err++; $display("FAIL b2b_mult_hi: got %h want 0", Hi); end
    n_cmp++; if (Lo !== 32'h1) begin n_err++; $display("FAIL b2b_mult_lo: got %h want 1", Lo); end
    Start = 1'b1; Op = 3'd1; In1 = 32'd2; In2 = 32'd3;
    @(negedge clk);
    Start = 1'b0; Op = 3'd6;
    n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got %b want 1", Busy); end
    n = 0;
    while (Busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d want 33", n); end
    n_cmp++; if (Lo !== 32'd6 || Hi !== 32'd0) begin
      n_err++; $display("FAIL b2b_multu: got %h_%h want 00000000_00000006", Hi, Lo);
    end
  endtask

  task automatic test_div;
    int n; logic d1, d2; logic [31:0] h, l;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n, d1, d2, h, l);
    n_cmp++; if (l !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", l); end
    n_cmp++; if (h !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", h); end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n, d1, d2, h, l);
    n_cmp++; if (l !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", l); end
    n_cmp++; if (h !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 0", h); end
    run_op(3'd3, 32'd100, 32'd7, n, d1, d2, h, l);
    n_cmp++; if (l !== 32'd14 || h !== 32'd2) begin
      n_err++; $display("FAIL divu_basic: got hi=%h lo=%h want hi=2 lo=e", h, l);
    end
  endtask

  task automatic test_div_zero;
    int n; logic d1, d2; logic [31:0] h, l;
    run_op(3'd3, 32'd7, 32'd0, n, d1, d2, h, l);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL divz_latency: got %0d want 33", n); end
    n_cmp++; if (d1 !== 1'b1) begin n_err++; $display("FAIL divz_done: got %b want 1", d1); end
    n_cmp++; if (l !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo: got %h want ffffffff", l); end
    n_cmp++; if (h !== 32'd7) begin n_err++; $display("FAIL divz_hi: got %h want 7", h); end
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, n, d1, d2, h, l);
    n_cmp++; if (l !== 32'hFFFF_FFFF || h !== 32'hFFFF_FFF0) begin
      n_err++; $display("FAIL divz_signed: got hi=%h lo=%h want hi=fffffff0 lo=ffffffff", h, l);
    end
  endtask

  task automatic test_flush;
    int dn;
    @(negedge clk);
    Start = 1'b1; Op = 3'd4; In1 = 32'h11;
    @(negedge clk);
    n_cmp++; if (Busy !== 1'b0 || Hi !== 32'h11) begin
      n_err++; $display("FAIL mthi: got busy=%b hi=%h want busy=0 hi=11", Busy, Hi);
    end
    Op = 3'd5; In1 = 32'h22;
    @(negedge clk);
    Start = 1'b0; Op = 3'd6;
    n_cmp++; if (Busy !== 1'b0 || Lo !== 32'h22 || Done !== 1'b0) begin
      n_err++; $display("FAIL mtlo: got busy=%b lo=%h done=%b want 0/22/0", Busy, Lo, Done);
    end
    issue(3'd3, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL flush_calc_busy: got %b want 0", Busy); end
    dn = 0;
    repeat (40) begin if (Done === 1'b1) dn++; @(negedge clk); end
    n_cmp++; if (dn !== 0) begin n_err++; $display("FAIL flush_calc_done: got %0d pulses want 0", dn); end
    n_cmp++; if (Hi !== 32'h11 || Lo !== 32'h22) begin
      n_err++; $display("FAIL flush_calc_hilo: got %h/%h want 11/22", Hi, Lo);
    end
    issue(3'd1, 32'd2, 32'd3);
    repeat (32) @(negedge clk);
    n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL flush_fix_pre: got busy %b want 1", Busy); end
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    n_cmp++; if (Busy !== 1'b0 || Done !== 1'b0 || Lo !== 32'h22 || Hi !== 32'h11) begin
      n_err++; $display("FAIL flush_fix: got busy=%b done=%b hi=%h lo=%h want 0/0/11/22", Busy, Done, Hi, Lo);
    end
    Flush = 1'b1; Start = 1'b1; Op = 3'd4; In1 = 32'h99;
    @(negedge clk);
    Flush = 1'b0; Start = 1'b0; Op = 3'd6;
    n_cmp++; if (Hi !== 32'h11 || Busy !== 1'b0) begin
      n_err++; $display("FAIL flush_mthi: got hi=%h busy=%b want hi=11 busy=0", Hi, Busy);
    end
    Flush = 1'b1; Start = 1'b1; Op = 3'd0; In1 = 32'd4; In2 = 32'd4;
    @(negedge clk);
    Flush = 1'b0; Start = 1'b0; Op = 3'd6;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL flush_start: got busy=%b want 0", Busy); end
  endtask

  task automatic test_start_while_busy;
    int n;
    issue(3'd3, 32'd100, 32'd3);
    repeat (5) @(negedge clk);
    Start = 1'b1; Op = 3'd0; In1 = 32'd5; In2 = 32'd5;
    @(negedge clk);
    Start = 1'b0; Op = 3'd6;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    n_cmp++; if (n !== 27) begin n_err++; $display("FAIL busy_start_len: got %0d want 27", n); end
    n_cmp++; if (Lo !== 32'd33 || Hi !== 32'd1) begin
      n_err++; $display("FAIL busy_start_result: got hi=%h lo=%h want hi=1 lo=21", Hi, Lo);
    end
    @(negedge clk);
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL busy_start_queued: got busy=%b want 0", Busy); end
  endtask

  task automatic test_reset_mid;
    int dn;
    issue(3'd1, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (Busy !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
      n_err++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", Busy, Hi, Lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin if (Done === 1'b1 || Busy === 1'b1) dn++; @(negedge clk); end
    n_cmp++; if (dn !== 0) begin n_err++; $display("FAIL reset_mid_after: got %0d active cycles want 0", dn); end
    n_cmp++; if (Lo !== 32'h0) begin n_err++; $display("FAIL reset_mid_lo: got %h want 0", Lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_flush();
    test_start_while_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
